assoc_data_array: RTL and testbench

- Next-generation cache data store: NUM_WAYS-way set-associative, byte-enable CPU writes, registered (1-cycle) CPU reads.
- Line refill from memory arrives as a multi-beat burst; dirty-line eviction leaves as a valid/ready beat stream.
- Sits between the cache controller FSM, the tag array and the memory interface.
- Holds data only; validity, dirty and LRU state live in the tag array.

---
 rtl/cache_pkg.sv | 44 ++++
 rtl/data_way_ram.sv | 30 +++
 rtl/assoc_data_array.sv | 184 ++++++++++++++++++
 tb/tb_assoc_data_array.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM state type and byte-merge helper for the cache data store
package cache_pkg;

  localparam int MAX_WORD_W = 1024;
  localparam int MAX_BE_W   = MAX_WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    EVICT_RD,
    EVICT_TX
  } state_t;

  function automatic int calc_set_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  function automatic int calc_word_sel_w(input int words_per_line);
    return (words_per_line > 1) ? $clog2(words_per_line) : 1;
  endfunction

  function automatic int calc_be_w(input int word_width);
    return word_width / 8;
  endfunction

  // Operates on the widest supported word; callers zero-extend and truncate.
  function automatic logic [MAX_WORD_W-1:0] be_merge(
    input logic [MAX_WORD_W-1:0] old_word,
    input logic [MAX_WORD_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_WORD_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_BE_W; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_way_ram.sv
// rtl/data_way_ram.sv - one cache way: single-port RAM with byte-enable write and registered read-first output
module data_way_ram
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int WORD_WIDTH = 32,
  parameter int BE_W       = WORD_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [BE_W-1:0]       be,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_W];

  // Read-first: a same-cycle read and write of one word returns the old contents.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= WORD_WIDTH'(be_merge(MAX_WORD_W'(mem[addr]), MAX_WORD_W'(wdata), MAX_BE_W'(be)));
      end
    end
  end

endmodule

// File: rtl/assoc_data_array.sv
// rtl/assoc_data_array.sv - set-associative cache data store with CPU port, burst refill and beat-stream eviction
module assoc_data_array
  import cache_pkg::*;
#(
  parameter int NUM_SETS       = 256,
  parameter int NUM_WAYS       = 4,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int SET_W      = calc_set_w(NUM_SETS),
  localparam int WAY_W      = calc_way_w(NUM_WAYS),
  localparam int WORD_SEL_W = calc_word_sel_w(WORDS_PER_LINE),
  localparam int BE_W       = calc_be_w(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd_en,
  input  logic                  cpu_wr_en,
  input  logic [SET_W-1:0]      cpu_set,
  input  logic [WAY_W-1:0]      cpu_way,
  input  logic [WORD_SEL_W-1:0] cpu_word,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  input  logic [BE_W-1:0]       cpu_be,
  output logic                  cpu_ready,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  refill_start,
  input  logic [SET_W-1:0]      refill_set,
  input  logic [WAY_W-1:0]      refill_way,
  input  logic                  refill_beat_valid,
  input  logic [WORD_WIDTH-1:0] refill_beat_data,
  output logic                  refill_done,
  input  logic                  evict_start,
  input  logic [SET_W-1:0]      evict_set,
  input  logic [WAY_W-1:0]      evict_way,
  output logic                  evict_valid,
  output logic [WORD_WIDTH-1:0] evict_data,
  output logic                  evict_last,
  input  logic                  evict_ready,
  output logic                  busy
);

  localparam int CNT_W  = WORD_SEL_W + 1;
  localparam int ADDR_W = SET_W + WORD_SEL_W;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic refill_done_d, evict_valid_d, evict_last_d;
  logic last_word;

  logic                  port_en, port_we;
  logic [WAY_W-1:0]      port_way;
  logic [ADDR_W-1:0]     port_addr;
  logic [BE_W-1:0]       port_be;
  logic [WORD_WIDTH-1:0] port_wdata;
  logic [WORD_WIDTH-1:0] way_rdata [NUM_WAYS];

  logic [WAY_W-1:0]      rd_way_q;
  logic [WORD_WIDTH-1:0] rdata_hold_q;

  assign cpu_ready = (state_q == IDLE);
  assign busy      = !cpu_ready;
  assign last_word = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));

  // The RAM output register doubles as the read register; the hold copy keeps
  // cpu_rdata stable once eviction traffic reuses the port.
  assign cpu_rdata  = cpu_rvalid ? way_rdata[rd_way_q] : rdata_hold_q;
  assign evict_data = evict_valid ? way_rdata[way_q] : '0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    set_d         = set_q;
    way_d         = way_q;
    refill_done_d = 1'b0;
    evict_valid_d = evict_valid;
    evict_last_d  = evict_last;
    port_en       = 1'b0;
    port_we       = 1'b0;
    port_way      = way_q;
    port_addr     = {set_q, cnt_q[WORD_SEL_W-1:0]};
    port_be       = '1;
    port_wdata    = refill_beat_data;

    case (state_q)
      IDLE: begin
        port_en    = cpu_rd_en || cpu_wr_en;
        port_we    = cpu_wr_en;
        port_way   = cpu_way;
        port_addr  = {cpu_set, cpu_word};
        port_be    = cpu_be;
        port_wdata = cpu_wdata;
        if (evict_start) begin
          set_d   = evict_set;
          way_d   = evict_way;
          cnt_d   = '0;
          state_d = EVICT_RD;
        end else if (refill_start) begin
          set_d   = refill_set;
          way_d   = refill_way;
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (refill_beat_valid) begin
          port_en = 1'b1;
          port_we = 1'b1;
          if (last_word) begin
            cnt_d         = '0;
            refill_done_d = 1'b1;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVICT_RD: begin
        port_en       = 1'b1;
        evict_valid_d = 1'b1;
        evict_last_d  = last_word;
        state_d       = EVICT_TX;
      end
      EVICT_TX: begin
        if (evict_ready) begin
          evict_valid_d = 1'b0;
          evict_last_d  = 1'b0;
          if (evict_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = EVICT_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      set_q        <= '0;
      way_q        <= '0;
      refill_done  <= 1'b0;
      evict_valid  <= 1'b0;
      evict_last   <= 1'b0;
      cpu_rvalid   <= 1'b0;
      rd_way_q     <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      set_q       <= set_d;
      way_q       <= way_d;
      refill_done <= refill_done_d;
      evict_valid <= evict_valid_d;
      evict_last  <= evict_last_d;
      cpu_rvalid  <= cpu_ready && cpu_rd_en;
      if (cpu_ready && cpu_rd_en) rd_way_q <= cpu_way;
      if (cpu_rvalid) rdata_hold_q <= way_rdata[rd_way_q];
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    data_way_ram #(
      .ADDR_W    (ADDR_W),
      .WORD_WIDTH(WORD_WIDTH),
      .BE_W      (BE_W)
    ) u_ram (
      .clk  (clk),
      .en   (port_en && (port_way == WAY_W'(w))),
      .we   (port_we),
      .addr (port_addr),
      .be   (port_be),
      .wdata(port_wdata),
      .rdata(way_rdata[w])
    );
  end

endmodule

// File: tb/tb_assoc_data_array.sv
// tb/tb_assoc_data_array.sv - directed self-checking bench for assoc_data_array
module tb_assoc_data_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en, cpu_wr_en;
  logic [7:0]  cpu_set;
  logic [1:0]  cpu_way, cpu_word;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ready, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        refill_start, refill_beat_valid, refill_done;
  logic [7:0]  refill_set;
  logic [1:0]  refill_way;
  logic [31:0] refill_beat_data;
  logic        evict_start, evict_valid, evict_last, evict_ready, busy;
  logic [7:0]  evict_set;
  logic [1:0]  evict_way;
  logic [31:0] evict_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] line_data [4];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  set;
    logic [1:0]  way;
    logic [1:0]  word;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  assoc_data_array dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_set(cpu_set), .cpu_way(cpu_way),
    .cpu_word(cpu_word), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .refill_start(refill_start), .refill_set(refill_set), .refill_way(refill_way),
    .refill_beat_valid(refill_beat_valid), .refill_beat_data(refill_beat_data), .refill_done(refill_done),
    .evict_start(evict_start), .evict_set(evict_set), .evict_way(evict_way),
    .evict_valid(evict_valid), .evict_data(evict_data), .evict_last(evict_last),
    .evict_ready(evict_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] s, input logic [1:0] w,
                              input logic [1:0] wd, input logic [31:0] d, input logic [3:0] be,
                              input logic erv, input logic [31:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.set = s; v.way = w; v.word = wd;
    v.wdata = d; v.be = be; v.exp_rvalid = erv; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic cpu_read(input logic [7:0] s, input logic [1:0] w, input logic [1:0] wd,
                          input logic [31:0] exp, input string name);
    cpu_rd_en = 1'b1; cpu_set = s; cpu_way = w; cpu_word = wd;
    step();
    cpu_rd_en = 1'b0;
    chk({name, " rvalid"}, 32'(cpu_rvalid), 32'd1);
    chk({name, " rdata"}, cpu_rdata, exp);
    step();
    chk({name, " rvalid drop"}, 32'(cpu_rvalid), 32'd0);
  endtask

  // Refill of line_data; optional gap after one beat and optional CPU/evict pokes while busy.
  task automatic do_refill(input logic [7:0] s, input logic [1:0] w, input int gap_after,
                           input bit poke, input logic [31:0] hold_rdata);
    refill_start = 1'b1; refill_set = s; refill_way = w;
    step();
    refill_start = 1'b0;
    chk("refill busy", 32'(busy), 32'd1);
    if (poke) begin
      cpu_rd_en = 1'b1; cpu_wr_en = 1'b1; cpu_set = 8'd5; cpu_way = 2'd2; cpu_word = 2'd3;
      cpu_wdata = 32'h0; cpu_be = 4'hF;
      evict_start = 1'b1; evict_set = 8'd5; evict_way = 2'd2;
      step();
      cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; evict_start = 1'b0;
      chk("busy cpu_ready", 32'(cpu_ready), 32'd0);
      chk("busy rvalid", 32'(cpu_rvalid), 32'd0);
      step();
      chk("busy rvalid late", 32'(cpu_rvalid), 32'd0);
      chk("busy rdata hold", cpu_rdata, hold_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      refill_beat_valid = 1'b1;
      refill_beat_data  = line_data[i];
      step();
      if (i == gap_after) begin
        refill_beat_valid = 1'b0;
        step();
      end
      if (i < 3) chk($sformatf("refill_done early beat%0d", i), 32'(refill_done), 32'd0);
    end
    refill_beat_valid = 1'b0;
    chk("refill_done pulse", 32'(refill_done), 32'd1);
    chk("refill idle", 32'(busy), 32'd0);
    step();
    chk("refill_done single", 32'(refill_done), 32'd0);
  endtask

  // Evict expecting line_data; stalls the given beat for stall_cycles. Clears refill_start too.
  task automatic do_evict(input logic [7:0] s, input logic [1:0] w, input int stall_beat, input int stall_cycles);
    int beat, stall;
    bit just_hs;
    beat = 0; stall = 0; just_hs = 1'b0;
    evict_start = 1'b1; evict_set = s; evict_way = w;
    step();
    evict_start = 1'b0; refill_start = 1'b0; evict_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && beat < 4; cyc++) begin
      if (just_hs) chk("evict gap", 32'(evict_valid), 32'd0);
      just_hs = 1'b0;
      if (evict_valid) begin
        chk($sformatf("evict data beat%0d", beat), evict_data, line_data[beat]);
        chk($sformatf("evict last beat%0d", beat), 32'(evict_last), 32'(beat == 3));
        if (beat == stall_beat && stall < stall_cycles) begin
          evict_ready = 1'b0;
          stall++;
        end else begin
          evict_ready = 1'b1;
          beat++;
          just_hs = 1'b1;
        end
      end else begin
        evict_ready = 1'b1;
      end
      step();
    end
    evict_ready = 1'b0;
    chk("evict beat count", 32'(beat), 32'd4);
    chk("evict stall count", 32'(stall), 32'(stall_cycles));
    chk("evict idle", 32'(busy), 32'd0);
    chk("evict valid off", 32'(evict_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_rd_en = 0; cpu_wr_en = 0; cpu_set = 0; cpu_way = 0; cpu_word = 0; cpu_wdata = 0; cpu_be = 0;
    refill_start = 0; refill_set = 0; refill_way = 0; refill_beat_valid = 0; refill_beat_data = 0;
    evict_start = 0; evict_set = 0; evict_way = 0; evict_ready = 0;

    vecs[0]  = mk(0, 1, 8'd7, 2'd1, 2'd0, 32'h01020304, 4'b1111, 0, 32'h00000000);
    vecs[1]  = mk(1, 0, 8'd7, 2'd1, 2'd0, 32'h0,        4'b0000, 1, 32'h01020304);
    vecs[2]  = mk(0, 1, 8'd7, 2'd1, 2'd0, 32'hFFFFFFFF, 4'b1000, 0, 32'h01020304);
    vecs[3]  = mk(1, 0, 8'd7, 2'd1, 2'd0, 32'h0,        4'b0000, 1, 32'hFF020304);
    vecs[4]  = mk(0, 1, 8'd7, 2'd1, 2'd0, 32'h000000AA, 4'b0001, 0, 32'hFF020304);
    vecs[5]  = mk(1, 0, 8'd7, 2'd1, 2'd0, 32'h0,        4'b0000, 1, 32'hFF0203AA);
    vecs[6]  = mk(0, 1, 8'd7, 2'd1, 2'd0, 32'h12345678, 4'b0000, 0, 32'hFF0203AA);
    vecs[7]  = mk(1, 0, 8'd7, 2'd1, 2'd0, 32'h0,        4'b0000, 1, 32'hFF0203AA);
    vecs[8]  = mk(1, 1, 8'd7, 2'd1, 2'd0, 32'h55667788, 4'b1111, 1, 32'hFF0203AA);
    vecs[9]  = mk(1, 0, 8'd7, 2'd1, 2'd0, 32'h0,        4'b0000, 1, 32'h55667788);
    vecs[10] = mk(0, 1, 8'd7, 2'd3, 2'd0, 32'hDEADBEEF, 4'b1111, 0, 32'h55667788);
    vecs[11] = mk(1, 0, 8'd7, 2'd1, 2'd0, 32'h0,        4'b0000, 1, 32'h55667788);
    vecs[12] = mk(1, 0, 8'd7, 2'd3, 2'd0, 32'h0,        4'b0000, 1, 32'hDEADBEEF);
    vecs[13] = mk(0, 0, 8'd7, 2'd3, 2'd0, 32'h0,        4'b0000, 0, 32'hDEADBEEF);

    step();
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cpu_ready", 32'(cpu_ready), 32'd1);
    chk("reset rvalid", 32'(cpu_rvalid), 32'd0);
    chk("reset rdata", cpu_rdata, 32'd0);
    chk("reset refill_done", 32'(refill_done), 32'd0);
    chk("reset evict_valid", 32'(evict_valid), 32'd0);
    chk("reset evict_last", 32'(evict_last), 32'd0);
    chk("reset evict_data", evict_data, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      cpu_rd_en = vecs[i].rd; cpu_wr_en = vecs[i].wr; cpu_set = vecs[i].set; cpu_way = vecs[i].way;
      cpu_word = vecs[i].word; cpu_wdata = vecs[i].wdata; cpu_be = vecs[i].be;
      step();
      chk($sformatf("vec%0d rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].exp_rvalid));
      chk($sformatf("vec%0d rdata", i), cpu_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d ready", i), 32'(cpu_ready), 32'd1);
    end
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;

    line_data[0] = 32'h11111111; line_data[1] = 32'h22222222;
    line_data[2] = 32'h33333333; line_data[3] = 32'h44444444;
    do_refill(8'd5, 2'd2, 1, 1'b0, 32'h0);
    cpu_read(8'd5, 2'd2, 2'd2, 32'h33333333, "refill rd w2");

    cpu_wr_en = 1'b1; cpu_set = 8'd5; cpu_way = 2'd2; cpu_word = 2'd0;
    cpu_wdata = 32'hAABBCCDD; cpu_be = 4'b0101;
    step();
    cpu_wr_en = 1'b0;
    chk("be write rvalid", 32'(cpu_rvalid), 32'd0);
    cpu_read(8'd5, 2'd2, 2'd0, 32'h11BB11DD, "be merge rd");

    line_data[0] = 32'h11BB11DD;
    do_evict(8'd5, 2'd2, 1, 3);

    refill_start = 1'b1; refill_set = 8'd5; refill_way = 2'd2;
    refill_beat_valid = 1'b1; refill_beat_data = 32'hBAD0BAD0;
    do_evict(8'd5, 2'd2, -1, 0);
    refill_beat_valid = 1'b0;
    step();
    chk("dropped refill idle", 32'(busy), 32'd0);
    cpu_read(8'd5, 2'd2, 2'd1, 32'h22222222, "no write during evict");

    line_data[0] = 32'hB0B0B0B0; line_data[1] = 32'hB1B1B1B1;
    line_data[2] = 32'hB2B2B2B2; line_data[3] = 32'hB3B3B3B3;
    do_refill(8'd9, 2'd0, -1, 1'b0, 32'h0);
    cpu_read(8'd9, 2'd0, 2'd3, 32'hB3B3B3B3, "later refill rd");

    line_data[0] = 32'hA0A0A0A0; line_data[1] = 32'hA1A1A1A1;
    line_data[2] = 32'hA2A2A2A2; line_data[3] = 32'hA3A3A3A3;
    do_refill(8'd9, 2'd1, -1, 1'b1, 32'hB3B3B3B3);
    cpu_read(8'd5, 2'd2, 2'd3, 32'h44444444, "busy write ignored");
    cpu_read(8'd9, 2'd1, 2'd2, 32'hA2A2A2A2, "busy refill rd");

    refill_start = 1'b1; refill_set = 8'd12; refill_way = 2'd3;
    step();
    refill_start = 1'b0;
    refill_beat_valid = 1'b1; refill_beat_data = 32'h00000001;
    step();
    refill_beat_data = 32'h00000002; rst = 1'b1;
    step();
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst refill_done", 32'(refill_done), 32'd0);
    chk("midrst rvalid", 32'(cpu_rvalid), 32'd0);
    chk("midrst rdata", cpu_rdata, 32'd0);
    chk("midrst evict_valid", 32'(evict_valid), 32'd0);
    chk("midrst evict_data", evict_data, 32'd0);
    rst = 1'b0; refill_beat_valid = 1'b0;
    step();
    line_data[0] = 32'hC0C0C0C0; line_data[1] = 32'hC1C1C1C1;
    line_data[2] = 32'hC2C2C2C2; line_data[3] = 32'hC3C3C3C3;
    do_refill(8'd12, 2'd3, 2, 1'b0, 32'h0);
    cpu_read(8'd12, 2'd3, 2'd0, 32'hC0C0C0C0, "post rst rd w0");
    cpu_read(8'd12, 2'd3, 2'd1, 32'hC1C1C1C1, "post rst rd w1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
